// File: rtl/int_sched_if.sv
// CPU-side bundle of int_sched: register window plus request/ack/done handshake.
// The CPU drives the master modport and int_sched drives the slave modport.
interface int_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            reg_sel;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] reg_wd;
  logic [DATA_WIDTH-1:0] reg_rd;
  logic                  int_req;
  logic [2:0]            int_id;
  logic                  int_ack;
  logic                  int_done;

  modport master (
    output reg_sel, reg_we, reg_wd, int_ack, int_done,
    input  reg_rd, int_req, int_id
  );

  modport slave (
    input  reg_sel, reg_we, reg_wd, int_ack, int_done,
    output reg_rd, int_req, int_id
  );
endinterface

// File: rtl/int_sched.sv
// Fixed-priority interrupt scheduler: latches, masks and presents up to 8 sources to the CPU.
// Define INT_SCHED_NEST_EN to let a higher-priority source preempt one that is in service.
module int_sched #(
  parameter int NUM_IRQ    = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  int_sched_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_PEND = 2'd0;
  localparam logic [1:0] SEL_MASK = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;

  state_e               state_q, state_d;
  logic [2:0]           int_id_q, int_id_d;
  logic [NUM_IRQ-1:0]   in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   mode_q, mode_d;
  logic [NUM_IRQ-1:0]   irq_q;

  logic [NUM_IRQ-1:0]   cand, rise, wr_clr, ack_clr, id_onehot, retired, edge_next;
  logic [NUM_IRQ-1:0]   wr_data;
  logic [2:0]           cand_idx;
  logic                 unused_wd;

  function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign wr_data   = bus.reg_wd[NUM_IRQ-1:0];
  assign unused_wd = ^bus.reg_wd[DATA_WIDTH-1:NUM_IRQ];

  assign cand      = pend_q & mask_q;
  assign cand_idx  = lowest_idx(cand);
  assign id_onehot = NUM_IRQ'(1) << int_id_q;
  assign retired   = in_service_q & (in_service_q - NUM_IRQ'(1));
  assign rise      = irq_in & ~irq_q;
  assign wr_clr    = (bus.reg_we && bus.reg_sel == SEL_PEND) ? wr_data : '0;

  // Edge bits: a rising edge in the same cycle as a clear keeps the bit set.
  assign edge_next = (pend_q & ~(wr_clr | ack_clr)) | rise;
  assign pend_d    = (mode_q & edge_next) | (~mode_q & irq_in);

  assign mask_d = (bus.reg_we && bus.reg_sel == SEL_MASK) ? wr_data : mask_q;
  assign mode_d = (bus.reg_we && bus.reg_sel == SEL_MODE) ? wr_data : mode_q;

`ifdef INT_SCHED_NEST_EN
  logic [2:0] svc_idx;
  assign svc_idx = lowest_idx(in_service_q);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d      = state_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d  = ST_REQ;
          int_id_d = cand_idx;
        end
      end
      ST_REQ: begin
        // A withdrawn source loses even if the ack arrives in the same cycle.
        if (!(|(cand & id_onehot))) begin
          state_d = (|in_service_q) ? ST_SERVICE : ST_IDLE;
        end else if (bus.int_ack) begin
          state_d      = ST_SERVICE;
          in_service_d = in_service_q | id_onehot;
          ack_clr      = id_onehot & mode_q;
        end
      end
      ST_SERVICE: begin
        if (bus.int_done) begin
          in_service_d = retired;
          if (retired == '0) state_d = ST_IDLE;
        end
`ifdef INT_SCHED_NEST_EN
        else if ((|cand) && (cand_idx < svc_idx)) begin
          state_d  = ST_REQ;
          int_id_d = cand_idx;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      int_id_q     <= '0;
      in_service_q <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      irq_q        <= '0;
    end else begin
      state_q      <= state_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      irq_q        <= irq_in;
    end
  end

  assign bus.int_req = (state_q == ST_REQ);
  assign bus.int_id  = int_id_q;

  always_comb begin
    bus.reg_rd = '0;
    case (bus.reg_sel)
      SEL_PEND: bus.reg_rd[NUM_IRQ-1:0] = pend_q;
      SEL_MASK: bus.reg_rd[NUM_IRQ-1:0] = mask_q;
      SEL_MODE: bus.reg_rd[NUM_IRQ-1:0] = mode_q;
      default: begin
        bus.reg_rd[15]            = (state_q == ST_REQ);
        bus.reg_rd[14:13]         = state_q;
        bus.reg_rd[10:8]          = int_id_q;
        bus.reg_rd[NUM_IRQ-1:0]   = in_service_q;
      end
    endcase
  end

endmodule

// File: tb/tb_int_sched.sv
// Directed, table-driven bench for int_sched; expected values are hand-derived.
// Build with +define+INT_SCHED_NEST_EN to exercise the preemption variant.
module tb_int_sched;

  localparam logic [1:0] PD = 2'd0, MK = 2'd1, MD = 2'd2, ST = 2'd3;

  typedef struct {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic        ack;
    logic        done;
    logic [1:0]  rsel;
    logic        exp_req;
    logic [2:0]  exp_id;
    logic [15:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       vq[$];

  int_sched_if #(.DATA_WIDTH(16)) bus ();

  int_sched #(.NUM_IRQ(8), .DATA_WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] irq, input logic we, input logic [1:0] sel,
                     input logic [15:0] wd, input logic ack, input logic done,
                     input logic [1:0] rsel, input logic er, input logic [2:0] eid,
                     input logic [15:0] erd);
    vq.push_back('{irq, we, sel, wd, ack, done, rsel, er, eid, erd});
  endtask

  initial begin
    int n;
    bus.reg_sel  = ST;
    bus.reg_we   = 1'b0;
    bus.reg_wd   = '0;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;

    //   irq    we sel wd     ack done rsel req id rd
    // reset state, edge source 0 end to end
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h0000);
    add(8'h00, 1, MK, 16'h01, 0, 0, MK, 0, 0, 16'h0001);
    add(8'h00, 1, MD, 16'h01, 0, 0, MD, 0, 0, 16'h0001);
    add(8'h01, 0, PD, 16'h00, 0, 0, PD, 0, 0, 16'h0001);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 0, 16'hA000);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 0, 16'hA000);
    add(8'h00, 0, PD, 16'h00, 1, 0, PD, 0, 0, 16'h0000);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h4001);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h0000);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 0, 16'h0000);
    // simultaneous edges on 5 and 2: priority, then one idle cycle
    add(8'h00, 1, MK, 16'hFF, 0, 0, MK, 0, 0, 16'h00FF);
    add(8'h00, 1, MD, 16'hFF, 0, 0, MD, 0, 0, 16'h00FF);
    add(8'h24, 0, PD, 16'h00, 0, 0, PD, 0, 0, 16'h0024);
    add(8'h24, 0, PD, 16'h00, 0, 0, ST, 1, 2, 16'hA200);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 2, 16'h4204);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 2, 16'h0200);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 5, 16'hA500);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 1, 5, 16'hA500);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 5, 16'h4520);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 5, 16'h0500);
    // masked pending bit 3, unmask, then withdraw by write-1-clear
    add(8'h00, 1, MK, 16'h00, 0, 0, MK, 0, 0, 16'h0000);
    add(8'h08, 0, PD, 16'h00, 0, 0, PD, 0, 0, 16'h0008);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h0500);
    add(8'h00, 1, MK, 16'h08, 0, 0, ST, 0, 0, 16'h0500);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 3, 16'hA300);
    add(8'h00, 1, PD, 16'h08, 0, 0, PD, 1, 3, 16'h0000);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h0300);
    // level source 1: re-request after done, withdraw when the line drops
    add(8'h00, 1, MD, 16'h00, 0, 0, MD, 0, 0, 16'h0000);
    add(8'h02, 1, MK, 16'h02, 0, 0, PD, 0, 0, 16'h0002);
    add(8'h02, 0, PD, 16'h00, 0, 0, ST, 1, 1, 16'hA100);
    add(8'h02, 0, PD, 16'h00, 1, 0, ST, 0, 0, 16'h4102);
    add(8'h02, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h0100);
    add(8'h02, 0, PD, 16'h00, 0, 0, ST, 1, 1, 16'hA100);
    add(8'h00, 0, PD, 16'h00, 0, 0, PD, 1, 1, 16'h0000);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 0, 16'h0100);
    // set beats clear on bit 4; stray done in IDLE
    add(8'h00, 1, MD, 16'h10, 0, 0, MD, 0, 0, 16'h0010);
    add(8'h00, 1, MK, 16'h00, 0, 0, MK, 0, 0, 16'h0000);
    add(8'h10, 1, PD, 16'h10, 0, 0, PD, 0, 0, 16'h0010);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h0100);
    // servicing id 4 when bit 1 fires
    add(8'h00, 1, MD, 16'h12, 0, 0, MD, 0, 0, 16'h0012);
    add(8'h00, 1, MK, 16'h12, 0, 0, ST, 0, 0, 16'h0100);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 4, 16'hA400);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 0, 16'h4410);
    add(8'h02, 0, PD, 16'h00, 0, 0, PD, 0, 0, 16'h0002);
`ifdef INT_SCHED_NEST_EN
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 1, 16'hA110);
    add(8'h00, 0, PD, 16'h00, 1, 0, ST, 0, 0, 16'h4112);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h4110);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h0100);
`else
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h4410);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 0, 0, 16'h4410);
    add(8'h00, 0, PD, 16'h00, 0, 1, ST, 0, 0, 16'h0400);
    add(8'h00, 0, PD, 16'h00, 0, 0, ST, 1, 1, 16'hA100);
`endif

    repeat (3) tick();
    rst_n = 1'b1;

    foreach (vq[i]) begin
      irq_in       = vq[i].irq;
      bus.reg_we   = vq[i].we;
      bus.reg_sel  = vq[i].sel;
      bus.reg_wd   = vq[i].wd;
      bus.int_ack  = vq[i].ack;
      bus.int_done = vq[i].done;
      tick();
      bus.reg_we   = 1'b0;
      bus.int_ack  = 1'b0;
      bus.int_done = 1'b0;
      bus.reg_sel  = vq[i].rsel;
      #1;
      check($sformatf("v%0d_req", i), 16'(bus.int_req), 16'(vq[i].exp_req));
      if (vq[i].exp_req) check($sformatf("v%0d_id", i), 16'(bus.int_id), 16'(vq[i].exp_id));
      check($sformatf("v%0d_rd", i), bus.reg_rd, vq[i].exp_rd);
    end

    // Get into SERVICE, then drop reset between clock edges.
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    n = 0;
    while (!bus.int_req && n < 8) begin
      tick();
      n++;
    end
    check("svc_req_seen", 16'(bus.int_req), 16'h0001);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.reg_sel = ST;
    #1;
    check("svc_state", 16'(bus.reg_rd[14:13]), 16'h0002);

    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", 16'(bus.int_req), 16'h0000);
    check("rst_id", 16'(bus.int_id), 16'h0000);
    check("rst_status", bus.reg_rd, 16'h0000);
    bus.reg_sel = PD;
    #1;
    check("rst_pend", bus.reg_rd, 16'h0000);
    bus.reg_sel = MK;
    #1;
    check("rst_mask", bus.reg_rd, 16'h0000);
    tick();
    rst_n = 1'b1;
    bus.reg_sel = ST;
    tick();
    check("post_rst_status", bus.reg_rd, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
